cpu_ctrl_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the 16-bit CPU, and the successor to the fixed ten-state controller. It decodes the instruction class presented after fetch and drives the datapath enables (PC, IR, regfile, ALU/bus mux, BRAM write, flags, link). Improvements over the previous controller:
- single-edge timing
- configurable BRAM read/write latency
- a pipeline-freeze stall input
- HALT and illegal-instruction handling
Sits between the instruction register decode logic and the datapath/BRAM.

---
 rtl/cpu_ctrl_sequencer_pkg.sv | 46 ++++
 rtl/cpu_ctrl_sequencer_if.sv | 33 +++
 rtl/ctrl_wait_counter.sv | 39 +++
 rtl/cpu_ctrl_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_ctrl_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_sequencer_pkg.sv
// Shared definitions for the multicycle control sequencer.
//   - instr_type class encodings delivered by the IR decode logic
//   - sequencer state encodings (4-bit state register)
//   - bit ordering of the internal datapath enable vector
package cpu_ctrl_sequencer_pkg;

  // Instruction classes; any value above ITYPE_HALT is illegal.
  localparam int unsigned ITYPE_RTYPE  = 0;
  localparam int unsigned ITYPE_STORE  = 1;
  localparam int unsigned ITYPE_LOAD   = 2;
  localparam int unsigned ITYPE_JUMP   = 3;
  localparam int unsigned ITYPE_BRANCH = 4;
  localparam int unsigned ITYPE_JAL    = 5;
  localparam int unsigned ITYPE_HALT   = 6;

  // Encodings 13..15 are unreachable and recover to StFetch.
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExec    = 4'd2,
    StStWr    = 4'd3,
    StStHold  = 4'd4,
    StLdAddr  = 4'd5,
    StLdWait  = 4'd6,
    StLdWb    = 4'd7,
    StJump    = 4'd8,
    StBranch  = 4'd9,
    StJal     = 4'd10,
    StHalt    = 4'd11,
    StIllegal = 4'd12
  } state_e;

  // Enable vector bit positions.
  localparam int unsigned EnPc      = 0;
  localparam int unsigned EnIr      = 1;
  localparam int unsigned EnR       = 2;
  localparam int unsigned EnAluBus  = 3;
  localparam int unsigned EnRegRead = 4;
  localparam int unsigned EnWrtBrm  = 5;
  localparam int unsigned EnFlags   = 6;
  localparam int unsigned EnLink    = 7;
  localparam int unsigned EnW       = 8;

  typedef logic [EnW-1:0] en_vec_t;

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// Control bus between IR decode / datapath and the sequencer.
//   master : IR decode side, drives instr_type/stall/resume, observes enables
//   slave  : sequencer, consumes instr_type/stall/resume, drives enables and status
interface cpu_ctrl_sequencer_if #(
  parameter int unsigned ITYPE_W = 3
);
  logic [ITYPE_W-1:0] instr_type;
  logic               stall;
  logic               resume;
  logic               PC_enable;
  logic               IR_enable;
  logic               R_enable;
  logic               ALU_Bus_enable;
  logic               reg_read;
  logic               WrtBrm_en;
  logic               Flags_Enable;
  logic               link_en;
  logic               halted;
  logic               illegal;
  logic               busy;

  modport master (
    output instr_type, stall, resume,
    input  PC_enable, IR_enable, R_enable, ALU_Bus_enable, reg_read, WrtBrm_en,
    input  Flags_Enable, link_en, halted, illegal, busy
  );

  modport slave (
    input  instr_type, stall, resume,
    output PC_enable, IR_enable, R_enable, ALU_Bus_enable, reg_read, WrtBrm_en,
    output Flags_Enable, link_en, halted, illegal, busy
  );
endinterface

// File: rtl/ctrl_wait_counter.sv
// Load/decrement wait counter shared by the LOAD and STORE paths.
//   clk, reset : clock, async active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   dec        : decrement, saturating at zero
//   zero       : count is 0
//   last       : count is 1, i.e. this is the final wait cycle
module ctrl_wait_counter #(
  parameter int unsigned WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero,
  output logic              last
);
  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == WAIT_W'(1));
endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Multicycle control sequencer for the 16-bit CPU.
//   clk   : system clock, all state changes on the rising edge
//   reset : async active-high reset; also forces every output low combinationally
//   bus   : slave side of cpu_ctrl_sequencer_if
//           in : instr_type, stall, resume
//           out: PC_enable, IR_enable, R_enable, ALU_Bus_enable, reg_read, WrtBrm_en,
//                Flags_Enable, link_en, halted, illegal, busy
module cpu_ctrl_sequencer
  import cpu_ctrl_sequencer_pkg::*;
#(
  parameter int unsigned ITYPE_W    = 3,
  parameter int unsigned LOAD_WAIT  = 1,
  parameter int unsigned STORE_HOLD = 1,
  parameter int unsigned WAIT_W     = 4
) (
  input logic                 clk,
  input logic                 reset,
  cpu_ctrl_sequencer_if.slave bus
);
  state_e            state_q, state_d;
  logic [ITYPE_W-1:0] itype;
  int unsigned       itype_int;
  logic              cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [WAIT_W-1:0] cnt_load_val;
  en_vec_t           en;
  logic              halted, illegal, busy;

  assign itype     = bus.instr_type;
  assign itype_int = 32'(itype);

  ctrl_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      StFetch: begin
        if (!bus.stall) state_d = StDecode;
      end
      StDecode: begin
        case (itype_int)
          ITYPE_RTYPE:  state_d = StExec;
          ITYPE_STORE:  state_d = StStWr;
          ITYPE_LOAD:   state_d = StLdAddr;
          ITYPE_JUMP:   state_d = StJump;
          ITYPE_BRANCH: state_d = StBranch;
          ITYPE_JAL:    state_d = StJal;
          ITYPE_HALT:   state_d = StHalt;
          default:      state_d = StIllegal;
        endcase
      end
      StExec: state_d = StFetch;
      StStWr: begin
        cnt_load     = 1'b1;
        cnt_load_val = WAIT_W'(STORE_HOLD);
        state_d      = (STORE_HOLD > 0) ? StStHold : StFetch;
      end
      StStHold: begin
        cnt_dec = 1'b1;
        // Leave on the cycle the counter steps to zero.
        if (cnt_last || cnt_zero) state_d = StFetch;
      end
      StLdAddr: begin
        cnt_load     = 1'b1;
        cnt_load_val = WAIT_W'(LOAD_WAIT);
        state_d      = (LOAD_WAIT > 0) ? StLdWait : StLdWb;
      end
      StLdWait: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) state_d = StLdWb;
      end
      StLdWb, StJump, StBranch, StJal: state_d = StFetch;
      StHalt, StIllegal: begin
        if (bus.resume) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    en      = '0;
    halted  = 1'b0;
    illegal = 1'b0;
    busy    = 1'b0;
    if (!reset) begin
      busy = !(state_q inside {StFetch, StHalt, StIllegal});
      case (state_q)
        StFetch: begin
          en[EnIr]     = !bus.stall;
          en[EnAluBus] = 1'b1;
        end
        StDecode: begin
          en[EnAluBus] = 1'b1;
          // PC stays put for JAL (link needs old PC), HALT and illegal codes.
          en[EnPc]     = (itype_int < ITYPE_JAL);
        end
        StExec: begin
          en[EnR]      = 1'b1;
          en[EnAluBus] = 1'b1;
          en[EnFlags]  = 1'b1;
        end
        StStWr: begin
          en[EnRegRead] = 1'b1;
          en[EnWrtBrm]  = 1'b1;
        end
        StStHold:           en[EnAluBus]  = 1'b1;
        StLdAddr, StLdWait: en[EnRegRead] = 1'b1;
        StLdWb:             en[EnR]       = 1'b1;
        StJump, StBranch:   en[EnAluBus]  = 1'b1;
        StJal: begin
          en[EnR]       = 1'b1;
          en[EnRegRead] = 1'b1;
          en[EnLink]    = 1'b1;
        end
        StHalt: halted = 1'b1;
        StIllegal: begin
          halted  = 1'b1;
          illegal = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.PC_enable      = en[EnPc];
  assign bus.IR_enable      = en[EnIr];
  assign bus.R_enable       = en[EnR];
  assign bus.ALU_Bus_enable = en[EnAluBus];
  assign bus.reg_read       = en[EnRegRead];
  assign bus.WrtBrm_en      = en[EnWrtBrm];
  assign bus.Flags_Enable   = en[EnFlags];
  assign bus.link_en        = en[EnLink];
  assign bus.halted         = halted;
  assign bus.illegal        = illegal;
  assign bus.busy           = busy;
endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Two sequencer instances with different wait settings share one stimulus
// stream; each is compared every cycle against an instruction-level model.
module tb_cpu_ctrl_sequencer;
  typedef logic [10:0] vec_t;  // {pc,ir,r,alu,rr,wb,fl,lk,halted,illegal,busy}

  localparam int unsigned LwA = 3, ShA = 2;
  localparam int unsigned LwB = 5, ShB = 0;
  localparam int MF = 0, MD = 1, MQ = 2, MH = 3, MI = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int mode [2];
  int kind [2];
  int idx  [2];
  int lw   [2];
  int sh   [2];

  cpu_ctrl_sequencer_if #(.ITYPE_W(3)) bus_a ();
  cpu_ctrl_sequencer_if #(.ITYPE_W(3)) bus_b ();

  cpu_ctrl_sequencer #(
    .ITYPE_W(3), .LOAD_WAIT(LwA), .STORE_HOLD(ShA), .WAIT_W(4)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  cpu_ctrl_sequencer #(
    .ITYPE_W(3), .LOAD_WAIT(LwB), .STORE_HOLD(ShB), .WAIT_W(4)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit pc, ir, r, alu, rr, wb, fl, lk, h, il, bz);
    return {pc, ir, r, alu, rr, wb, fl, lk, h, il, bz};
  endfunction

  function automatic vec_t obs_a();
    return {bus_a.PC_enable, bus_a.IR_enable, bus_a.R_enable, bus_a.ALU_Bus_enable,
            bus_a.reg_read, bus_a.WrtBrm_en, bus_a.Flags_Enable, bus_a.link_en,
            bus_a.halted, bus_a.illegal, bus_a.busy};
  endfunction

  function automatic vec_t obs_b();
    return {bus_b.PC_enable, bus_b.IR_enable, bus_b.R_enable, bus_b.ALU_Bus_enable,
            bus_b.reg_read, bus_b.WrtBrm_en, bus_b.Flags_Enable, bus_b.link_en,
            bus_b.halted, bus_b.illegal, bus_b.busy};
  endfunction

  // Cycles an instruction spends after DECODE.
  function automatic int body_len(input int k, input int l, input int s);
    case (k)
      1:       return 1 + s;
      2:       return 2 + l;
      default: return 1;
    endcase
  endfunction

  // Enables on cycle i after DECODE for instruction class k.
  function automatic vec_t body_vec(input int k, input int i, input int l);
    case (k)
      0: return mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
      1: return (i == 0) ? mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1)
                         : mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      2: return (i <= l) ? mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1)
                         : mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      5: return mk(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1);
      default: return mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    endcase
  endfunction

  task automatic model_step(input int d, input logic rst, input int it, input logic st,
                            input logic rs, output vec_t exp);
    exp = '0;
    if (rst) begin
      mode[d] = MF;
    end else begin
      case (mode[d])
        MF: begin
          exp = mk(0, !st, 0, 1, 0, 0, 0, 0, 0, 0, 0);
          if (!st) mode[d] = MD;
        end
        MD: begin
          exp = mk(it < 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
          if (it == 6) mode[d] = MH;
          else if (it > 6) mode[d] = MI;
          else begin
            mode[d] = MQ;
            kind[d] = it;
            idx[d]  = 0;
          end
        end
        MQ: begin
          exp = body_vec(kind[d], idx[d], lw[d]);
          idx[d]++;
          if (idx[d] >= body_len(kind[d], lw[d], sh[d])) mode[d] = MF;
        end
        MH: begin
          exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
          if (rs) mode[d] = MF;
        end
        default: begin
          exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
          if (rs) mode[d] = MF;
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs compared mid-cycle.
  task automatic cycle(input logic rst, input int it, input logic st, input logic rs);
    vec_t ea, eb;
    @(posedge clk);
    #1;
    cyc++;
    reset            = rst;
    bus_a.instr_type = 3'(it);
    bus_b.instr_type = 3'(it);
    bus_a.stall      = st;
    bus_b.stall      = st;
    bus_a.resume     = rs;
    bus_b.resume     = rs;
    #3;
    model_step(0, rst, it, st, rs, ea);
    model_step(1, rst, it, st, rs, eb);
    check("seq_a", obs_a(), ea);
    check("seq_b", obs_b(), eb);
  endtask

  task automatic run(input int it, input logic st, input logic rs, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, it, st, rs);
  endtask

  initial begin
    lw[0] = LwA; sh[0] = ShA;
    lw[1] = LwB; sh[1] = ShB;
    for (int d = 0; d < 2; d++) begin
      mode[d] = MF; kind[d] = 0; idx[d] = 0;
    end
    reset = 1'b1;
    bus_a.instr_type = '0; bus_b.instr_type = '0;
    bus_a.stall = 1'b0;    bus_b.stall = 1'b0;
    bus_a.resume = 1'b0;   bus_b.resume = 1'b0;

    // Reset, then two back-to-back R-type instructions.
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 0, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0, 6);

    // Stall in FETCH, HALT, simultaneous resume+stall, then illegal code 7.
    run(6, 1'b1, 1'b0, 4);
    run(6, 1'b0, 1'b0, 2);
    run(0, 1'b0, 1'b0, 5);
    cycle(1'b0, 0, 1'b1, 1'b1);
    run(7, 1'b1, 1'b0, 2);
    run(7, 1'b0, 1'b0, 5);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // JAL.
    run(5, 1'b0, 1'b0, 3);

    // LOAD interrupted by reset while both instances sit in LD_WAIT.
    run(2, 1'b0, 1'b0, 4);
    cycle(1'b1, 2, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 10);
    cycle(1'b1, 0, 1'b0, 1'b0);

    // STORE with hold 2 (instance a) and hold 0 (instance b).
    run(1, 1'b0, 1'b0, 15);
    cycle(1'b1, 0, 1'b0, 1'b0);

    // Randomised traffic with occasional stall, resume and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
